// File: rtl/tff_count_sequencer.sv
// rtl/tff_count_sequencer.sv - controller driving a bank of T flip-flops as an up/down counter
module tff_count_sequencer #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] base_next;
    logic             done_next;
    logic [WIDTH-1:0] t_int;
    logic [WIDTH-1:0] up_vec;
    logic [WIDTH-1:0] down_vec;
    logic             carry_up;
    logic             carry_down;

    // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_vec     = '0;
        down_vec   = '0;
        carry_up   = 1'b1;
        carry_down = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_vec[i]   = carry_up;
            down_vec[i] = carry_down;
            carry_up    = carry_up & q[i];
            carry_down  = carry_down & ~q[i];
        end
    end

    always_comb begin
        t_int      = '0;
        state_next = state;
        base_next  = base;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (load_en) begin
                    t_int = q ^ load_val;
                end
                if (start) begin
                    state_next = RUN;
                    base_next  = load_en ? load_val : q;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (pause) begin
                    state_next = RUN;
                end else if (q == limit) begin
                    done_next = 1'b1;
                    if (WRAP) begin
                        t_int = q ^ base;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    t_int = dir ? up_vec : down_vec;
                end
            end
            DONE: begin
                if (load_en) begin
                    t_int = q ^ load_val;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign t_vec = rst ? '0 : t_int;
    assign q_bar = ~q;
    assign busy  = (state == RUN);

    // The bank itself: q only ever changes through its toggle enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            state <= IDLE;
            base  <= '0;
            done  <= 1'b0;
        end else begin
            q     <= q ^ t_vec;
            state <= state_next;
            base  <= base_next;
            done  <= done_next;
        end
    end

endmodule
